// File: rtl/cam_pkg.sv
// Shared camera-path definitions.
//   - capture FSM state encoding
//   - RGB565 field positions within a 16-bit pixel word
//   - default active-window size, also used by the VGA readout side
package cam_pkg;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_FRAME  = 2'd2
    } cap_state_e;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

endpackage

// File: rtl/cap_byte_pair.sv
// Byte-pair assembler: joins two consecutive sensor bytes into one RGB565
// word (first byte high) and registers the result with its write strobe.
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   en_i         byte on d_i is valid and belongs to the current frame
//   clr_i        force phase back to 0 (frame start/end, line end)
//   drop_i       completed pixel must not be written (frame full)
//   d_i          registered sensor byte
//   done_o       a pixel completes this cycle (written or dropped)
//   lone_o       phase is 1: a first byte is waiting for its partner
//   pix_we_o     one-cycle write strobe
//   pix_data_o   assembled pixel, held until the next written pixel
module cap_byte_pair (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        drop_i,
    input  logic [7:0]  d_i,
    output logic        done_o,
    output logic        lone_o,
    output logic        pix_we_o,
    output logic [15:0] pix_data_o
);

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        pix_we_q, pix_we_d;
    logic [15:0] pix_data_q, pix_data_d;

    assign done_o     = en_i & phase_q;
    assign lone_o     = phase_q;
    assign pix_we_o   = pix_we_q;
    assign pix_data_o = pix_data_q;

    always_comb begin
        phase_d    = phase_q;
        hi_d       = hi_q;
        pix_we_d   = done_o & ~drop_i;
        pix_data_d = pix_data_q;
        // A completing pixel is still emitted when clr_i hits in the same
        // cycle; only the phase is forced back.
        if (clr_i) begin
            phase_d = 1'b0;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d_i;
            end
        end
        if (pix_we_d) begin
            pix_data_d = {hi_q, d_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            hi_q       <= '0;
            pix_we_q   <= 1'b0;
            pix_data_q <= '0;
        end else begin
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            pix_we_q   <= pix_we_d;
            pix_data_q <= pix_data_d;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture front-end (PCLK domain). Registers VSYNC/HREF/D once,
// assembles RGB565 pixels and produces a write strobe with a linear
// frame-buffer address. Flags malformed lines and frame overflow and
// reports the pixel total of each finished frame.
// Ports:
//   clk, rst_n     sensor PCLK, async active-low reset
//   vsync, href, d sensor timing and data inputs
//   pix_data       RGB565 pixel, first byte in [15:8]
//   pix_we         one-cycle write strobe (pix_data, wr_addr valid)
//   wr_addr        address of the pixel being written, 0 at frame start
//   frame_start    pulse on entry to S_FRAME
//   frame_done     pulse after a frame ends
//   frame_pixels   pixels written in the last completed frame
//   line_err       sticky per frame: odd byte count or wrong line length
//   ovf            sticky per frame: pixel beyond the window was dropped
//
// state    | meaning
// S_SYNC   | after reset, waiting for the first vsync high
// S_VBLANK | vertical blanking, waiting for vsync low
// S_FRAME  | active frame, bytes captured while href is high
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [15:0]       pix_data,
    output logic              pix_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_pixels,
    output logic              line_err,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(H_ACT * V_ACT);
    // One spare bit so an over-long line cannot wrap back onto H_ACT.
    localparam int LINE_W = $clog2(H_ACT + 1) + 1;

    cap_state_e state_q, state_d;

    logic              r_vsync_q, r_href_q, href_prev_q;
    logic [7:0]        r_d_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] frame_pixels_q, frame_pixels_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic              line_err_q, line_err_d;
    logic              ovf_q, ovf_d;
    logic              frame_start_q, frame_done_q;

    logic in_frame, frame_go, vs_rise, href_rise, href_fall;
    logic full, pix_done, pix_lone, pix_write;

    assign in_frame  = (state_q == S_FRAME);
    assign frame_go  = (state_q == S_VBLANK) & ~r_vsync_q;
    assign vs_rise   = in_frame & r_vsync_q;
    assign href_rise = r_href_q & ~href_prev_q;
    // Frame end wins over a line end in the same cycle.
    assign href_fall = in_frame & ~r_vsync_q & href_prev_q & ~r_href_q;
    assign full      = (pix_cnt_q == TOTAL);
    assign pix_write = pix_done & ~full;

    cap_byte_pair u_pair (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (in_frame & r_href_q),
        .clr_i      (frame_go | vs_rise | href_fall),
        .drop_i     (full),
        .d_i        (r_d_q),
        .done_o     (pix_done),
        .lone_o     (pix_lone),
        .pix_we_o   (pix_we),
        .pix_data_o (pix_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC:   if (r_vsync_q)  state_d = S_VBLANK;
            S_VBLANK: if (!r_vsync_q) state_d = S_FRAME;
            S_FRAME:  if (r_vsync_q)  state_d = S_VBLANK;
            default:                  state_d = S_SYNC;
        endcase
    end

    always_comb begin
        wr_addr_d      = wr_addr_q;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        line_err_d     = line_err_q;
        ovf_d          = ovf_q;
        frame_pixels_d = frame_pixels_q;

        if (frame_go) begin
            wr_addr_d  = '0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            line_err_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            // wr_addr advances after each strobe but parks on the last
            // address once the window is full.
            if (pix_we && (wr_addr_q != TOTAL - ADDR_W'(1))) begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
            if (pix_write) begin
                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            end
            if (href_rise) begin
                line_cnt_d = '0;
            end else if (pix_done && (line_cnt_q != '1)) begin
                line_cnt_d = line_cnt_q + LINE_W'(1);
            end
            if (href_fall && (pix_lone || (line_cnt_q != LINE_W'(H_ACT)))) begin
                line_err_d = 1'b1;
            end
            if (pix_done && full) begin
                ovf_d = 1'b1;
            end
        end

        if (vs_rise) begin
            frame_pixels_d = pix_cnt_q + ADDR_W'(pix_write);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_SYNC;
            r_vsync_q      <= 1'b0;
            r_href_q       <= 1'b0;
            r_d_q          <= '0;
            href_prev_q    <= 1'b0;
            wr_addr_q      <= '0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            line_err_q     <= 1'b0;
            ovf_q          <= 1'b0;
            frame_pixels_q <= '0;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_vsync_q      <= vsync;
            r_href_q       <= href;
            r_d_q          <= d;
            href_prev_q    <= r_href_q;
            wr_addr_q      <= wr_addr_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            line_err_q     <= line_err_d;
            ovf_q          <= ovf_d;
            frame_pixels_q <= frame_pixels_d;
            frame_start_q  <= frame_go;
            frame_done_q   <= vs_rise;
        end
    end

    assign wr_addr      = wr_addr_q;
    assign frame_pixels = frame_pixels_q;
    assign line_err     = line_err_q;
    assign ovf          = ovf_q;
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 16x6 window.
module tb_ov7670_capture;

    localparam int H     = 16;
    localparam int V     = 6;
    localparam int AW    = 7;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    d = 8'h00;
    logic [15:0]   pix_data;
    logic          pix_we;
    logic [AW-1:0] wr_addr;
    logic          frame_start;
    logic          frame_done;
    logic [AW-1:0] frame_pixels;
    logic          line_err;
    logic          ovf;

    ov7670_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .href         (href),
        .d            (d),
        .pix_data     (pix_data),
        .pix_we       (pix_we),
        .wr_addr      (wr_addr),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .line_err     (line_err),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries: {address[15:0], pixel[15:0]}
    logic [31:0] sb_q[$];
    bit  cap_on   = 1'b0;
    int  exp_cnt  = 0;
    bit  exp_lerr = 1'b0;
    bit  exp_ovf  = 1'b0;

    int  we_cnt = 0, last_addr = 0;
    int  fs_rises = 0, fd_rises = 0, fd_hi = 0, fd_mark = 0;
    logic fs_prev = 1'b0, fd_prev = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (pix_we) begin
            we_cnt++;
            last_addr = int'(wr_addr);
            if (sb_q.size() == 0) begin
                chk("unexpected_we", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("pix_addr", 32'(wr_addr), 32'(e[31:16]));
                chk("pix_data", 32'(pix_data), 32'(e[15:0]));
            end
        end
        if (frame_start && !fs_prev) fs_rises++;
        if (frame_done && !fd_prev) fd_rises++;
        if (frame_done) fd_hi++;
        fs_prev = frame_start;
        fd_prev = frame_done;
    end

    // Bytes 0,1,2,... per line; vs_last raises vsync together with the last byte.
    task automatic drive_bytes(input int nbytes, input bit vs_last);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            href = 1'b1;
            d    = i[7:0];
            if (vs_last && i == nbytes - 1) vsync = 1'b1;
            if (i[0] && cap_on) begin
                if (exp_cnt < TOTAL) begin
                    sb_q.push_back({exp_cnt[15:0], 8'(i - 1), 8'(i)});
                    exp_cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_line(input int nbytes, input bit vs_last);
        drive_bytes(nbytes, vs_last);
        @(negedge clk);
        href = 1'b0;
        d    = 8'h00;
        if (!vs_last && cap_on && ((nbytes % 2) != 0 || (nbytes / 2) != H)) exp_lerr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_begin();
        int fs0;
        @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        fs0     = fs_rises;
        fd_mark = fd_rises;
        vsync   = 1'b0;
        for (int k = 0; k < 20 && fs_rises == fs0; k++) @(negedge clk);
        chk("frame_start", 32'(fs_rises), 32'(fs0 + 1));
        chk("start_addr", 32'(wr_addr), 32'd0);
        chk("start_lerr", 32'(line_err), 32'd0);
        chk("start_ovf", 32'(ovf), 32'd0);
        cap_on   = 1'b1;
        exp_cnt  = 0;
        exp_lerr = 1'b0;
        exp_ovf  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        vsync  = 1'b1;
        cap_on = 1'b0;
        for (int k = 0; k < 20 && fd_rises == fd_mark; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("frame_done", 32'(fd_rises), 32'(fd_mark + 1));
        chk("fd_width", 32'(fd_hi), 32'(fd_rises));
        chk("frame_pixels", 32'(frame_pixels), 32'(exp_cnt));
        chk("frame_ovf", 32'(ovf), 32'(exp_ovf));
        chk("frame_lerr", 32'(line_err), 32'(exp_lerr));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_we", 32'(pix_we), 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_fpix", 32'(frame_pixels), 32'd0);
        chk("rst_lerr", 32'(line_err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // vsync already low after reset: must stay idle in S_SYNC
        we0 = we_cnt;
        drive_line(2 * H, 1'b0);
        chk("sync_no_we", 32'(we_cnt), 32'(we0));

        // single good line
        frame_begin();
        we0 = we_cnt;
        drive_line(2 * H, 1'b0);
        chk("line_we_cnt", 32'(we_cnt - we0), 32'(H));
        chk("last_addr", 32'(last_addr), 32'(H - 1));
        chk("line_err_good", 32'(line_err), 32'(exp_lerr));
        frame_end();

        // full frame
        frame_begin();
        for (int l = 0; l < V; l++) drive_line(2 * H, 1'b0);
        frame_end();

        // odd-length line, then a good line must start at phase 0
        frame_begin();
        drive_line(2 * H - 1, 1'b0);
        chk("line_err_odd", 32'(line_err), 32'(exp_lerr));
        drive_line(2 * H, 1'b0);
        frame_end();

        // even but short line
        frame_begin();
        drive_line(2 * H - 4, 1'b0);
        chk("line_err_short", 32'(line_err), 32'(exp_lerr));
        frame_end();

        // one line too many: last line dropped
        frame_begin();
        for (int l = 0; l <= V; l++) drive_line(2 * H, 1'b0);
        chk("ovf_addr", 32'(wr_addr), 32'(TOTAL - 1));
        chk("ovf_mid", 32'(ovf), 32'(exp_ovf));
        frame_end();

        // vsync rises together with a completing pixel mid-line
        frame_begin();
        drive_line(2 * H, 1'b0);
        drive_line(6, 1'b1);
        frame_end();

        // reset mid-line, released with vsync low and href active
        frame_begin();
        drive_bytes(20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        cap_on = 1'b0;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        we0 = we_cnt;
        drive_line(2 * H, 1'b0);
        chk("post_rst_no_we", 32'(we_cnt), 32'(we0));
        frame_begin();
        drive_line(2 * H, 1'b0);
        frame_end();

        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Capture front-end for the camera sensor. Runs in the sensor pixel-clock domain and samples VSYNC, HREF and the 8-bit data bus.
- Assembles byte pairs into RGB565 pixels and emits one write strobe plus a linear frame-buffer address per pixel.
- Feeds the frame-buffer write port and the pixel counters downstream. pix_we is the intended count enable for those counters.
- Detects malformed lines and frame overflow, and reports the pixel total of each completed frame.

Parameters:
- H_ACT, 640, active pixels per line (used for line_err checking).
- V_ACT, 480, active lines per frame.
- ADDR_W, 19, width of wr_addr and frame_pixels; must satisfy 2^ADDR_W >= H_ACT*V_ACT.

Ports:
- clk  in  1  sensor pixel clock (PCLK); all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- vsync  in  1  sensor VSYNC, high during vertical blanking
- href  in  1  sensor HREF, high while line bytes are valid
- d  in  8  sensor data bus
- pix_data  out  16  assembled RGB565 pixel, first byte in [15:8]
- pix_we  out  1  one-cycle write strobe, pix_data and wr_addr valid
- wr_addr  out  ADDR_W  linear address of current pixel, 0 at frame start
- frame_start  out  1  one-cycle pulse on entry to S_FRAME
- frame_done  out  1  one-cycle pulse when a frame ends
- frame_pixels  out  ADDR_W  pixels written in last completed frame
- line_err  out  1  sticky per frame: odd byte count or line length != H_ACT
- ovf  out  1  sticky per frame: pixel beyond H_ACT*V_ACT dropped

Behaviour:
- Reset: all outputs 0, FSM in S_SYNC, byte phase 0, input registers 0.
- Input stage: vsync, href and d are registered once (r_vsync, r_href, r_d). All decisions use the registered values.
- FSM:
  - S_SYNC: wait for r_vsync=1, then go to S_VBLANK. No partial frame is ever captured after reset.
  - S_VBLANK: on r_vsync falling (1 to 0), go to S_FRAME. Pulse frame_start the next cycle. Clear wr_addr, line_err, ovf, byte phase and the line-length counter.
  - S_FRAME: capture bytes. On r_vsync rising, go to S_VBLANK. Pulse frame_done the next cycle. Load frame_pixels with the count of written pixels in the same cycle.
- Byte assembly:
  - Only in S_FRAME with r_href=1. Phase 0 stores r_d as the high byte. Phase 1 forms {high, r_d} and toggles phase.
  - pix_we asserts for one cycle two edges after the second byte is present on d: input register, then output register.
  - pix_data and wr_addr are stable while pix_we is high.
- Address:
  - wr_addr holds the address of the pixel being written.
  - It increments by 1 on the cycle after each pix_we.
  - Max written address is H_ACT*V_ACT-1.
- Overflow:
  - A completed pixel whose address would be >= H_ACT*V_ACT is dropped: no pix_we, wr_addr holds, ovf is set.
  - wr_addr never wraps.
- Line end (r_href falling):
  - If phase=1, discard the lone byte, reset phase to 0, set line_err.
  - If the pixels in that line != H_ACT, set line_err.
  - The line-length counter resets on every r_href rise.
- Simultaneous events:
  - If r_href=1 while r_vsync rises, the frame end takes priority. A pending partial pixel is discarded without setting line_err.
  - A pixel completed in the same cycle as vsync rise is still written and counted.
- Outside S_FRAME: href activity is ignored and pix_we stays 0.
- Reset mid-frame: everything clears immediately. Capture resumes only after a full vsync high-to-low sequence, via S_SYNC.

Decomposition:
- Shared package cam_pkg holds:
  - the FSM state enum (S_SYNC, S_VBLANK, S_FRAME);
  - RGB565 field positions (R [15:11], G [10:5], B [4:0]);
  - default H_ACT/V_ACT constants shared with the VGA readout side.
- One natural sub-module, cap_byte_pair. It contains:
  - phase toggle;
  - high-byte register;
  - pixel output register;
  - lone-byte detection.
- ov7670_capture keeps the FSM, address, line-length counter and error flags.

Test Plan:
- Reset, then vsync 1 to 0 and one href line of 1280 bytes 0x00..0xFF repeating -> frame_start pulse; 640 pix_we; first pix_data=0x0001 at wr_addr=0; last wr_addr=639; line_err=0.
- Full 640x480 frame, then vsync rise -> frame_done one cycle; frame_pixels=307200; ovf=0; next frame first write at wr_addr=0.
- Line of 1279 bytes -> 639 pixels written; lone byte discarded; line_err=1; next line starts at phase 0; flag clears at next frame_start.
- 481 full lines in one frame -> pixels 0..307199 written; remaining 640 dropped; ovf=1; wr_addr stays 307199; frame_pixels=307200.
- rst_n asserted mid-line at pixel 100, then released with vsync low and href active -> no pix_we until vsync high then low; first write at wr_addr=0.
- Capture started with vsync already low after reset -> stays in S_SYNC; zero pix_we until the first vsync high period ends.
